doorlock_ctrl: RTL and testbench

Parametrised successor to the two-key doorlock sequencer. Accepts an N-digit code between start/end keypresses, compares it to a stored code, and holds the door open for a programmable time. Adds entry timeout, failed-attempt counting and a timed lockout. Sits between the keypad debouncer/pulse generator and the door actuator/display driver.

---
 rtl/doorlock_pkg.sv | 25 ++
 rtl/doorlock_code_buf.sv | 55 +++++
 rtl/doorlock_ctrl.sv | 131 +++++++++++++
 tb/tb_doorlock_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/doorlock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// doorlock_pkg : state encodings and timer-width helper for doorlock_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
package doorlock_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/doorlock_code_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// doorlock_code_buf : digit shift buffer, saturating digit counter, comparator
// Revision 1.0
// ---------------------------------------------------------------------------
module doorlock_code_buf
  import doorlock_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [3:0]            digit,
  input  logic [4*DIGITS-1:0]   code,
  output logic                  overflow,
  output logic                  match
);

  localparam int CW = $clog2(DIGITS + 2);
  localparam logic [CW-1:0] C_FULL  = CW'(DIGITS);
  localparam logic [CW-1:0] C_OVER  = CW'(DIGITS + 1);

  logic [4*DIGITS-1:0] digits_q;
  logic [4*DIGITS-1:0] shifted;
  logic [CW-1:0]       count;

  generate
    if (DIGITS == 1) begin : g_single
      assign shifted = digit;
    end else begin : g_multi
      assign shifted = {digits_q[4*DIGITS-5:0], digit};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      count    <= '0;
    end else if (clear) begin
      digits_q <= '0;
      count    <= '0;
    end else if (shift) begin
      digits_q <= shifted;
      // Count saturates one past DIGITS so an over-long entry can never match
      if (count != C_OVER) count <= count + CW'(1);
    end
  end

  assign overflow = (count == C_OVER);
  assign match    = (count == C_FULL) && (digits_q == code);

endmodule
`default_nettype wire

// File: rtl/doorlock_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// doorlock_ctrl : N-digit code lock with entry timeout, failure count, lockout
// Revision 1.0
// ---------------------------------------------------------------------------
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int OPEN_CYCLES    = 5000,
  parameter int LOCK_CYCLES    = 20000,
  parameter int MAX_FAIL       = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps_start,
  input  logic                            ps_end,
  input  logic                            key_valid,
  input  logic [3:0]                      key_digit,
  input  logic [4*DIGITS-1:0]             code,
  output logic [2:0]                      state_out,
  output logic                            unlocked,
  output logic                            err,
  output logic                            alarm,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int TW = timer_width(OPEN_CYCLES, LOCK_CYCLES, TIMEOUT_CYCLES);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [FW-1:0] fail_nx, fail_inc;
  logic          err_nx, buf_clear, buf_shift, code_match, code_over;

  doorlock_code_buf #(.DIGITS(DIGITS)) u_code_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (buf_clear),
    .shift    (buf_shift),
    .digit    (key_digit),
    .code     (code),
    .overflow (code_over),
    .match    (code_match)
  );

  assign fail_inc = fail_cnt + FW'(1);

  always_comb begin
    state_nx  = state;
    timer_nx  = timer + TW'(1);
    fail_nx   = fail_cnt;
    err_nx    = 1'b0;
    buf_clear = 1'b0;
    buf_shift = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nx = '0;
        if (ps_start) begin
          state_nx  = S_ENTRY;
          buf_clear = 1'b1;
        end
      end
      S_ENTRY: begin
        // Priority: restart, then confirm (dropping a coincident digit), then digit
        if (ps_start) begin
          buf_clear = 1'b1;
          timer_nx  = '0;
        end else if (ps_end) begin
          state_nx = S_CHECK;
        end else if (key_valid) begin
          buf_shift = 1'b1;
          timer_nx  = '0;
        end else if (timer == TO_LAST) begin
          state_nx = S_IDLE;
          err_nx   = 1'b1;
        end
      end
      S_CHECK: begin
        if (code_match && !code_over) begin
          state_nx = S_OPEN;
          fail_nx  = '0;
        end else begin
          err_nx   = 1'b1;
          fail_nx  = fail_inc;
          state_nx = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
        end
      end
      S_OPEN: begin
        if (timer == OPEN_LAST) state_nx = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_nx = S_IDLE;
          fail_nx  = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (state_nx != state) timer_nx = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      fail_cnt <= fail_nx;
      err      <= err_nx;
      unlocked <= (state_nx == S_OPEN);
      alarm    <= (state_nx == S_LOCKOUT);
    end
  end

  assign state_out = state;

endmodule
`default_nettype wire

// File: tb/tb_doorlock_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_doorlock_ctrl : scoreboard bench for doorlock_ctrl (small timing params)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_doorlock_ctrl;

  localparam int DIGITS         = 4;
  localparam int OPEN_CYCLES    = 10;
  localparam int LOCK_CYCLES    = 20;
  localparam int MAX_FAIL       = 3;
  localparam int TIMEOUT_CYCLES = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps_start, ps_end, key_valid;
  logic [3:0]  key_digit;
  logic [15:0] code;
  logic [2:0]  state_out;
  logic        unlocked, err, alarm;
  logic [1:0]  fail_cnt;

  typedef struct packed {
    logic [2:0] st;
    logic       er;
    logic [1:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  doorlock_ctrl #(
    .DIGITS(DIGITS), .OPEN_CYCLES(OPEN_CYCLES), .LOCK_CYCLES(LOCK_CYCLES),
    .MAX_FAIL(MAX_FAIL), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .ps_start(ps_start), .ps_end(ps_end),
    .key_valid(key_valid), .key_digit(key_digit), .code(code),
    .state_out(state_out), .unlocked(unlocked), .err(err), .alarm(alarm),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Hold the given inputs across one rising edge, then return 1 time unit after it.
  task automatic drive(input logic s, input logic en, input logic kv, input logic [3:0] d);
    ps_start = s; ps_end = en; key_valid = kv; key_digit = d;
    @(posedge clk); #1;
    ps_start = 1'b0; ps_end = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
  endtask

  task automatic enter(input logic [31:0] digs, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, digs[4*(n-1-i) +: 4]);
  endtask

  task automatic measure_unlocked(output int n);
    n = 0;
    while (unlocked && n < 1000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic measure_alarm(output int n);
    n = 0;
    while (alarm && n < 1000) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset;
    rst = 1'b1; ps_start = 0; ps_end = 0; key_valid = 0; key_digit = 0; code = 16'h1234;
    #2;
    checks++;
    if ({state_out, unlocked, err, alarm, fail_cnt} !== 7'd0) begin
      errors++; $display("FAIL reset_during: got %b expected 0", {state_out, unlocked, err, alarm, fail_cnt});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({state_out, unlocked, err, alarm, fail_cnt} !== 7'd0) begin
      errors++; $display("FAIL reset_after: got %b expected 0", {state_out, unlocked, err, alarm, fail_cnt});
    end
  endtask

  task automatic test_open;
    int n;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter(32'h1234, 4);
    sb.push_back('{st: 3'd3, er: 1'b0, fc: 2'd0});
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (state_out !== 3'd2) begin errors++; $display("FAIL open_check_state: got %0d expected 2", state_out); end
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e) begin
      errors++; $display("FAIL open_outcome: got %b expected %b", {state_out, err, fail_cnt}, e);
    end
    measure_unlocked(n);
    checks++;
    if (n !== OPEN_CYCLES) begin errors++; $display("FAIL open_duration: got %0d expected %0d", n, OPEN_CYCLES); end
    checks++;
    if (state_out !== 3'd0 || fail_cnt !== 2'd0) begin
      errors++; $display("FAIL open_exit: got state %0d fail %0d expected 0 0", state_out, fail_cnt);
    end
  endtask

  task automatic test_mismatch;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter(32'h1235, 4);
    sb.push_back('{st: 3'd0, er: 1'b1, fc: 2'd1});
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e) begin
      errors++; $display("FAIL mismatch_outcome: got %b expected %b", {state_out, err, fail_cnt}, e);
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b expected 0", err); end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter(32'h12344, 5);
    sb.push_back('{st: 3'd0, er: 1'b1, fc: 2'd2});
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e) begin
      errors++; $display("FAIL overflow_outcome: got %b expected %b", {state_out, err, fail_cnt}, e);
    end
  endtask

  task automatic test_lockout;
    int n, m;
    // Third consecutive failure, following the two from test_mismatch
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter(32'h9999, 4);
    sb.push_back('{st: 3'd4, er: 1'b1, fc: 2'd3});
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e || alarm !== 1'b1) begin
      errors++; $display("FAIL lockout_entry: got %b alarm %b expected %b alarm 1", {state_out, err, fail_cnt}, alarm, e);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    checks++;
    if (state_out !== 3'd4) begin errors++; $display("FAIL lockout_ignore_start: got %0d expected 4", state_out); end
    measure_alarm(m);
    n = m + 1;
    checks++;
    if (n !== LOCK_CYCLES) begin errors++; $display("FAIL lockout_duration: got %0d expected %0d", n, LOCK_CYCLES); end
    checks++;
    if (state_out !== 3'd0 || fail_cnt !== 2'd0) begin
      errors++; $display("FAIL lockout_exit: got state %0d fail %0d expected 0 0", state_out, fail_cnt);
    end
  endtask

  task automatic test_timeout;
    int n;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd1);
    sb.push_back('{st: 3'd0, er: 1'b1, fc: 2'd0});
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (err || state_out !== 3'd1) break;
    end
    checks++;
    if (n !== TIMEOUT_CYCLES) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT_CYCLES); end
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e) begin
      errors++; $display("FAIL timeout_outcome: got %b expected %b", {state_out, err, fail_cnt}, e);
    end
    // A digit in the last idle cycle before expiry must restart the timer
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd1);
    repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b1, 4'd2);
    checks++;
    if (state_out !== 3'd1 || err !== 1'b0) begin
      errors++; $display("FAIL timeout_restart: got state %0d err %b expected 1 0", state_out, err);
    end
    enter(32'h34, 2);
    sb.push_back('{st: 3'd3, er: 1'b0, fc: 2'd0});
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e) begin
      errors++; $display("FAIL timeout_restart_open: got %b expected %b", {state_out, err, fail_cnt}, e);
    end
    measure_unlocked(n);
  endtask

  task automatic test_collisions;
    int n;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter(32'h123, 3);
    sb.push_back('{st: 3'd0, er: 1'b1, fc: 2'd1});
    drive(1'b0, 1'b1, 1'b1, 4'd4);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e) begin
      errors++; $display("FAIL end_with_key: got %b expected %b", {state_out, err, fail_cnt}, e);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter(32'h19, 2);
    drive(1'b1, 1'b0, 1'b1, 4'd7);
    enter(32'h1234, 4);
    sb.push_back('{st: 3'd3, er: 1'b0, fc: 2'd0});
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({state_out, err, fail_cnt} !== e) begin
      errors++; $display("FAIL restart_open: got %b expected %b", {state_out, err, fail_cnt}, e);
    end
    measure_unlocked(n);
    checks++;
    if (n !== OPEN_CYCLES) begin errors++; $display("FAIL restart_open_duration: got %0d expected %0d", n, OPEN_CYCLES); end
  endtask

  task automatic test_reset_mid_open;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    enter(32'h1234, 4);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state_out, unlocked, err, alarm, fail_cnt} !== 7'd0) begin
      errors++; $display("FAIL reset_mid_open: got %b expected 0", {state_out, unlocked, err, alarm, fail_cnt});
    end
    @(posedge clk); #1 rst = 1'b0;
    test_open();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_open();
    test_mismatch();
    test_lockout();
    test_timeout();
    test_collisions();
    test_reset_mid_open();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
